// File: rtl/vector_split_unpack_pkg.sv
// Shared field layout and entry type for the packed-word unpacker.
// The packed word is {byte-reversed hi[31:0], pad[7:0], lo[23:0]}.
package vector_split_unpack_pkg;

    localparam int unsigned HI_MSB  = 63;
    localparam int unsigned HI_LSB  = 32;
    localparam int unsigned PAD_MSB = 31;
    localparam int unsigned PAD_LSB = 24;
    localparam int unsigned LO_MSB  = 23;

    localparam logic [7:0] PAD_VALUE = 8'h00;

    typedef struct packed {
        logic [31:0] hi;
        logic [23:0] lo;
        logic        pad_err;
    } entry_t;

    function automatic logic [31:0] byte_reverse32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/vector_split_unpack_if.sv
// Input link, output FIFO head and error-counter signals of the unpacker.
// The slave modport is the unpacker; the master modport is its environment.
interface vector_split_unpack_if #(
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic [63:0]      in_data;
    logic             in_ready;
    logic             out_valid;
    logic [31:0]      out_hi;
    logic [23:0]      out_lo;
    logic             out_pad_err;
    logic             out_ready;
    logic [CNT_W-1:0] err_count;
    logic             clr_err;

    modport master (
        output in_valid, in_data, out_ready, clr_err,
        input  in_ready, out_valid, out_hi, out_lo, out_pad_err, err_count
    );

    modport slave (
        input  in_valid, in_data, out_ready, clr_err,
        output in_ready, out_valid, out_hi, out_lo, out_pad_err, err_count
    );
endinterface

// File: rtl/vector_split_unpack_fifo.sv
// DEPTH-entry synchronous FIFO for decoded entries; ready/valid derive only
// from the registered count, and the head reads as zero while empty.
module split_fifo
    import vector_split_unpack_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push_i,
    input  entry_t wdata_i,
    input  logic   pop_i,
    output logic   in_ready_o,
    output logic   out_valid_o,
    output entry_t rdata_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CW    = PTR_W + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign in_ready_o  = (count_q < FULL);
    assign out_valid_o = (count_q != '0);
    assign rdata_o     = out_valid_o ? mem_q[rptr_q] : '0;

    // Gate internally so an external push-while-full or pop-while-empty is ignored.
    assign do_push = push_i && in_ready_o;
    assign do_pop  = pop_i && out_valid_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/vector_split_unpack.sv
// Receive-side unpacker: decodes packed words, buffers {hi, lo, pad_err}
// in a small FIFO and keeps a saturating count of bad-pad words.
module vector_split_unpack
    import vector_split_unpack_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    vector_split_unpack_if.slave  bus
);
    entry_t           dec;
    entry_t           head;
    logic             push;
    logic             pop;
    logic             in_ready;
    logic             out_valid;
    logic [CNT_W-1:0] err_q, err_d;

    always_comb begin
        dec.hi      = byte_reverse32(bus.in_data[HI_MSB:HI_LSB]);
        dec.lo      = bus.in_data[LO_MSB:0];
        dec.pad_err = (bus.in_data[PAD_MSB:PAD_LSB] != PAD_VALUE);
    end

    assign push = bus.in_valid && in_ready;
    assign pop  = out_valid && bus.out_ready;

    split_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .wdata_i     (dec),
        .pop_i       (pop),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .rdata_o     (head)
    );

    // Clear wins over a same-cycle increment; the counter holds at all-ones.
    always_comb begin
        err_d = err_q;
        if (bus.clr_err)
            err_d = '0;
        else if (push && dec.pad_err && (err_q != '1))
            err_d = err_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= '0;
        else      err_q <= err_d;
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_hi      = head.hi;
    assign bus.out_lo      = head.lo;
    assign bus.out_pad_err = head.pad_err;
    assign bus.err_count   = err_q;

endmodule

// File: tb/tb_vector_split_unpack.sv
// Self-checking bench for vector_split_unpack: directed table, corner
// sequences, a randomized phase against a queue model, and a CNT_W=2 instance.
module tb_vector_split_unpack;

    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vector_split_unpack_if #(.CNT_W(16)) bus ();
    vector_split_unpack_if #(.CNT_W(2))  bus2 ();

    vector_split_unpack #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    vector_split_unpack #(.DEPTH(DEPTH), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    typedef struct {
        logic [63:0] din;
        logic [31:0] hi;
        logic [23:0] lo;
        logic        pad;
        logic [15:0] err;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [23:0] lo;
        logic        pad;
    } mdl_t;

    mdl_t        q[$];
    int unsigned m_err;

    function automatic mdl_t model_decode(input logic [63:0] d);
        mdl_t        m;
        longint unsigned v = d;
        longint unsigned raw = v >> 32;
        longint unsigned h = 0;
        for (int i = 0; i < 4; i++)
            h += ((raw >> (8 * i)) % 256) << (8 * (3 - i));
        m.hi  = h[31:0];
        m.lo  = 24'(v % (64'd1 << 24));
        m.pad = (((v >> 24) % 256) != 0);
        return m;
    endfunction

    task automatic check_vs_model(input string tag);
        mdl_t h;
        chk({tag, ".out_valid"}, bus.out_valid, q.size() != 0);
        chk({tag, ".in_ready"},  bus.in_ready,  q.size() < DEPTH);
        if (q.size() != 0) h = q[0];
        else begin h.hi = '0; h.lo = '0; h.pad = 1'b0; end
        chk({tag, ".out_hi"},      bus.out_hi,      h.hi);
        chk({tag, ".out_lo"},      bus.out_lo,      h.lo);
        chk({tag, ".out_pad_err"}, bus.out_pad_err, h.pad);
        chk({tag, ".err_count"},   bus.err_count,   m_err);
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{64'h11223344_00ABCDEF, 32'h44332211, 24'hABCDEF, 1'b0, 16'd0};
        vecs[1] = '{64'hDEADBEEF_5A000001, 32'hEFBEADDE, 24'h000001, 1'b1, 16'd1};
        vecs[2] = '{64'h01020304_00000000, 32'h04030201, 24'h000000, 1'b0, 16'd1};
        vecs[3] = '{64'hFFFFFFFF_FFFFFFFF, 32'hFFFFFFFF, 24'hFFFFFF, 1'b1, 16'd2};

        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0; bus.clr_err = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.out_ready = 1'b0; bus2.clr_err = 1'b0;

        #1;
        chk("rst.out_valid", bus.out_valid, 1'b0);
        chk("rst.in_ready",  bus.in_ready,  1'b1);
        chk("rst.out_hi",    bus.out_hi,    32'h0);
        chk("rst.out_lo",    bus.out_lo,    24'h0);
        chk("rst.out_pad",   bus.out_pad_err, 1'b0);
        chk("rst.err",       bus.err_count, 16'h0);
        step();
        rst = 1'b1;
        step();

        // Directed table: push one word, check head one cycle later, drain.
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in_data = vecs[i].din; bus.out_ready = 1'b0;
            step();
            bus.in_valid = 1'b0;
            chk("tbl.out_valid", bus.out_valid, 1'b1);
            chk("tbl.out_hi",    bus.out_hi,    vecs[i].hi);
            chk("tbl.out_lo",    bus.out_lo,    vecs[i].lo);
            chk("tbl.out_pad",   bus.out_pad_err, vecs[i].pad);
            chk("tbl.err",       bus.err_count, vecs[i].err);
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
            chk("tbl.drained", bus.out_valid, 1'b0);
        end

        // Backpressure: fill, hold off a third word, then drain in order.
        bus.in_valid = 1'b1; bus.in_data = 64'hA0A1A2A3_00000001;
        step();
        chk("bp.ready_after1", bus.in_ready, 1'b1);
        bus.in_data = 64'hB0B1B2B3_00000002;
        step();
        chk("bp.ready_full", bus.in_ready, 1'b0);
        chk("bp.head_a", bus.out_hi, 32'hA3A2A1A0);
        bus.in_data = 64'hC0C1C2C3_00000003;
        step();
        chk("bp.held_ready", bus.in_ready, 1'b0);
        chk("bp.held_head",  bus.out_hi, 32'hA3A2A1A0);
        bus.out_ready = 1'b1;
        step();
        chk("bp.head_b",      bus.out_hi, 32'hB3B2B1B0);
        chk("bp.ready_back",  bus.in_ready, 1'b1);
        step();
        chk("bp.head_c",      bus.out_hi, 32'hC3C2C1C0);
        chk("bp.lo_c",        bus.out_lo, 24'h000003);
        bus.in_valid = 1'b0;
        step();
        chk("bp.empty", bus.out_valid, 1'b0);
        bus.out_ready = 1'b0;

        // Clear coincident with a bad-pad push: clear wins, word still delivered.
        bus.clr_err = 1'b1; bus.in_valid = 1'b1; bus.in_data = 64'h12345678_FF000042;
        step();
        bus.clr_err = 1'b0; bus.in_valid = 1'b0;
        chk("clr.err",      bus.err_count, 16'h0);
        chk("clr.pad_flag", bus.out_pad_err, 1'b1);
        chk("clr.lo",       bus.out_lo, 24'h000042);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // Randomized phase against the queue model.
        q.delete();
        m_err = 0;
        for (int c = 0; c < 400; c++) begin
            logic        pu, po;
            logic [63:0] d;
            check_vs_model("rnd");
            d = {$urandom, $urandom};
            if ($urandom_range(1, 0) == 0) d[31:24] = 8'h00;
            bus.in_data   = d;
            bus.in_valid  = ($urandom_range(3, 0) != 0);
            bus.out_ready = ($urandom_range(2, 0) != 0);
            bus.clr_err   = ($urandom_range(15, 0) == 0);
            pu = bus.in_valid && (q.size() < DEPTH);
            po = bus.out_ready && (q.size() != 0);
            @(posedge clk);
            if (bus.clr_err) m_err = 0;
            else if (pu && model_decode(d).pad && m_err < 65535) m_err++;
            if (po) void'(q.pop_front());
            if (pu) q.push_back(model_decode(d));
            step();
        end
        check_vs_model("rnd_end");
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.clr_err = 1'b0;

        // Drain leftovers before the reset test.
        bus.out_ready = 1'b1;
        step(); step();
        bus.out_ready = 1'b0;
        chk("pre_rst.empty", bus.out_valid, 1'b0);

        // Asynchronous reset with two entries buffered.
        bus.in_valid = 1'b1; bus.in_data = 64'h01010101_AA000001;
        step();
        bus.in_data = 64'h02020202_00000002;
        step();
        bus.in_valid = 1'b0;
        chk("mid.two_buffered", bus.in_ready, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("mid.out_valid", bus.out_valid, 1'b0);
        chk("mid.in_ready",  bus.in_ready,  1'b1);
        chk("mid.out_hi",    bus.out_hi,    32'h0);
        chk("mid.err",       bus.err_count, 16'h0);
        step();
        rst = 1'b1;
        step();
        chk("post_rst.out_valid", bus.out_valid, 1'b0);
        chk("post_rst.in_ready",  bus.in_ready,  1'b1);

        // Saturation on the CNT_W=2 instance.
        bus2.out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            bus2.in_valid = 1'b1;
            bus2.in_data  = {32'(k), 8'h80, 24'(k)};
            step();
            chk("sat.err", bus2.err_count, (k < 3) ? k : 3);
        end
        bus2.in_valid = 1'b0;
        step();
        chk("sat.hold", bus2.err_count, 2'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
